// File: rtl/noc_packetizer_pkg.sv
// Shared NoC types: flit layout, packet header, VC/credit sizing and the packetizer state encoding.
package params_noc;

    localparam int x_Des              = 4;
    localparam int y_Des              = 4;
    localparam int header_Payloadsize = 16;
    localparam int flit_Size          = x_Des + y_Des + header_Payloadsize;
    localparam int vc_Num             = 2;
    localparam int VC_Size            = (vc_Num > 1) ? $clog2(vc_Num) : 1;
    localparam int max_Body_Flits     = 8;
    localparam int credit_Depth       = 4;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_Data_Label;

    typedef struct packed {
        logic [x_Des-1:0]              x_Dest;
        logic [y_Des-1:0]              y_Dest;
        logic [header_Payloadsize-1:0] header_Payload;
    } packet_Header;

    // A head flit carries the routing header; every other flit carries a raw data word.
    typedef union packed {
        packet_Header         head_Data;
        logic [flit_Size-1:0] flit;
    } flit_Payload;

    typedef struct packed {
        flit_Data_Label     flit_Label;
        logic [VC_Size-1:0] vc_Id;
        flit_Payload        data;
    } flit_Data_withvc;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } pkt_state_e;

    function automatic logic [VC_Size-1:0] next_vc(input logic [VC_Size-1:0] vc);
        return (int'(vc) == vc_Num - 1) ? '0 : vc + VC_Size'(1);
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Descriptor, body-word, flit and credit signals of the packetizer; slave is the packetizer side.
interface noc_packetizer_if #(
    parameter int MAX_BODY = params_noc::max_Body_Flits
);
    import params_noc::*;

    localparam int LEN_W = $clog2(MAX_BODY + 1);

    // Descriptor and body words transfer on a rising edge where valid && ready; the source holds
    // valid and its payload stable until that edge. flit_valid_o is a one-cycle event with no
    // ready; the only flow control on flits is the per-VC credit returned through credit_i.
    logic                          pkt_valid_i;
    logic                          pkt_ready_o;
    logic [x_Des-1:0]              pkt_x_dest_i;
    logic [y_Des-1:0]              pkt_y_dest_i;
    logic [header_Payloadsize-1:0] pkt_payload_i;
    logic [LEN_W-1:0]              pkt_len_i;
    logic                          data_valid_i;
    logic                          data_ready_o;
    logic [flit_Size-1:0]          data_i;
    logic                          flit_valid_o;
    flit_Data_withvc               flit_o;
    logic [vc_Num-1:0]             credit_i;

    modport master (
        output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_payload_i, pkt_len_i,
        output data_valid_i, data_i, credit_i,
        input  pkt_ready_o, data_ready_o, flit_valid_o, flit_o
    );

    modport slave (
        input  pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_payload_i, pkt_len_i,
        input  data_valid_i, data_i, credit_i,
        output pkt_ready_o, data_ready_o, flit_valid_o, flit_o
    );

endinterface

// File: rtl/noc_packetizer_credit.sv
// Per-VC saturating credit counter: starts full, counts down on emission and up on returned credit.
module vc_credit_counter #(
    parameter int DEPTH = params_noc::credit_Depth,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic avail_o
);

    logic [CW-1:0] count_q, count_d;

    // Simultaneous return and spend cancel; a return at full count is dropped.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CW'(DEPTH)) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CW'(DEPTH);
        end else begin
            count_q <= count_d;
        end
    end

    assign avail_o = (count_q != '0);

    credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc_i && !dec_i && count_q == CW'(DEPTH)))
        else $error("credit returned to a VC already at full credit");

endmodule

// File: rtl/noc_packetizer.sv
// Turns packet descriptors plus body words into credit-gated HEAD/BODY/TAIL flits on round-robin VCs.
// Optional NOC_PACKETIZER_STATS_EN adds packet and flit counters.
module noc_packetizer
    import params_noc::*;
#(
    parameter int MAX_BODY     = max_Body_Flits,
    parameter int CREDIT_DEPTH = credit_Depth
) (
    input  logic               clk,
    input  logic               rst_n,
    noc_packetizer_if.slave    bus,
    output pkt_state_e         state_o
`ifdef NOC_PACKETIZER_STATS_EN
    ,
    output logic [31:0]        pkt_count_o,
    output logic [31:0]        flit_count_o
`endif
);

    localparam int LEN_W = $clog2(MAX_BODY + 1);

    pkt_state_e         state_q, state_d;
    logic [VC_Size-1:0] vc_q, vc_d;
    packet_Header       hdr_q, hdr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    flit_Data_withvc    flit_q, flit_d;
    logic               flit_valid_q;
    logic               emit;
    logic [vc_Num-1:0]  avail;
    logic [vc_Num-1:0]  dec;
    logic               vc_avail;
    logic [LEN_W-1:0]   len_clamped;

    for (genvar gv = 0; gv < vc_Num; gv++) begin : g_credit
        vc_credit_counter #(.DEPTH(CREDIT_DEPTH)) u_credit (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (bus.credit_i[gv]),
            .dec_i   (dec[gv]),
            .avail_o (avail[gv])
        );
    end

    assign vc_avail    = avail[vc_q];
    assign len_clamped = (int'(bus.pkt_len_i) > MAX_BODY) ? LEN_W'(MAX_BODY) : bus.pkt_len_i;

    always_comb begin
        dec       = '0;
        dec[vc_q] = emit;
    end

    // vc_q doubles as last_vc: it is advanced on accept and then held for the whole packet.
    always_comb begin
        state_d          = state_q;
        vc_d             = vc_q;
        hdr_d            = hdr_q;
        rem_d            = rem_q;
        flit_d           = flit_q;
        emit             = 1'b0;
        bus.pkt_ready_o  = 1'b0;
        bus.data_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.pkt_ready_o = 1'b1;
                if (bus.pkt_valid_i) begin
                    vc_d                 = next_vc(vc_q);
                    hdr_d.x_Dest         = bus.pkt_x_dest_i;
                    hdr_d.y_Dest         = bus.pkt_y_dest_i;
                    hdr_d.header_Payload = bus.pkt_payload_i;
                    rem_d                = len_clamped;
                    state_d              = S_HEAD;
                end
            end
            S_HEAD: begin
                if (vc_avail) begin
                    emit                  = 1'b1;
                    flit_d.vc_Id          = vc_q;
                    flit_d.data.head_Data = hdr_q;
                    if (rem_q == '0) begin
                        flit_d.flit_Label = HEADTAIL;
                        state_d           = S_IDLE;
                    end else begin
                        flit_d.flit_Label = HEAD;
                        state_d           = S_BODY;
                    end
                end
            end
            S_BODY: begin
                bus.data_ready_o = vc_avail;
                if (bus.data_valid_i && vc_avail) begin
                    emit             = 1'b1;
                    flit_d.vc_Id     = vc_q;
                    flit_d.data.flit = bus.data_i;
                    rem_d            = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        flit_d.flit_Label = TAIL;
                        state_d           = S_IDLE;
                    end else begin
                        flit_d.flit_Label = BODY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vc_q         <= VC_Size'(vc_Num - 1);
            hdr_q        <= '0;
            rem_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vc_q         <= vc_d;
            hdr_q        <= hdr_d;
            rem_q        <= rem_d;
            flit_q       <= flit_d;
            flit_valid_q <= emit;
        end
    end

    assign bus.flit_valid_o = flit_valid_q;
    assign bus.flit_o       = flit_q;
    assign state_o          = state_q;

`ifdef NOC_PACKETIZER_STATS_EN
    logic [31:0] pkt_count_q, flit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else if (emit) begin
            flit_count_q <= flit_count_q + 32'd1;
            if (flit_d.flit_Label == HEAD || flit_d.flit_Label == HEADTAIL) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign pkt_count_o  = pkt_count_q;
    assign flit_count_o = flit_count_q;
`endif

endmodule
